afu_irq_arbiter: RTL and testbench
==================================

# afu_irq_arbiter

Collects per-vector interrupt request pulses from every AFU and keeps one pending bit per vector. Issues exactly one interrupt at a time to the MSI-X table/TLP generator over a valid/ready handshake, arbitrating round-robin across AFUs and by fixed priority within an AFU. Sits between the AFU interrupt request lines and the FIM MSI-X request generator, sized from the FIM config package `NUM_AFUS` and `NUM_AFU_INTERRUPTS`.

## Interface
- `NUM_AFUS`, 1, number of AFU ports.
- `NUM_AFU_INTERRUPTS`, 7, vectors per AFU.
- `LNUM_AFUS`, `NUM_AFUS>1 ? $clog2(NUM_AFUS) : 1`, AFU index width.
- `L_NUM_AFU_INTERRUPTS`, `$clog2(NUM_AFU_INTERRUPTS)`, vector index width.
- `clk`  in  1  single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_afu_irq_req`  in  `NUM_AFUS*NUM_AFU_INTERRUPTS`  one-cycle request pulses; bit index = afu*NUM_AFU_INTERRUPTS + vec.
- `i_vec_mask`  in  `NUM_AFUS*NUM_AFU_INTERRUPTS`  per-vector mask, 1 = masked (only with `OFS_FIM_IRQ_MASK_EN`).
- `o_irq_pending`  out  `NUM_AFUS*NUM_AFU_INTERRUPTS`  registered pending-bit array.
- `o_msix_valid`  out  1  interrupt request valid.
- `o_msix_afu`  out  `LNUM_AFUS`  AFU index of request.
- `o_msix_vector`  out  `L_NUM_AFU_INTERRUPTS`  vector index of request.
- `i_msix_ready`  in  1  downstream accepts the request.
- `o_merge_cnt`  out  16  saturating count of coalesced requests.

## Operation
- Pending set: any `i_afu_irq_req` bit high sets its pending bit at the next edge.
- Coalescing: a pulse on a bit already pending, and not cleared that cycle, increments `o_merge_cnt` once per bit. Multiple such bits in one cycle add their popcount. The counter saturates at 0xFFFF.
- Eligible = pending & ~mask; without the macro, eligible = pending.
- FSM states:
  - IDLE: if any bit is eligible, select a winner, load `o_msix_afu`/`o_msix_vector`, clear the winner's pending bit, set `o_msix_valid`, and go to REQ. Otherwise stay in IDLE.
  - REQ: `o_msix_valid`=1 with afu/vector held stable. On `i_msix_ready`=1, drop valid at the next edge, update the RR pointer to the granted AFU, and go to IDLE.
- Winner selection:
  - Scan AFUs starting at (rr_ptr+1) mod NUM_AFUS; the first AFU with any eligible bit wins.
  - Within that AFU, the lowest eligible vector wins.
  - rr_ptr resets to NUM_AFUS-1, so AFU 0 has first priority.
- Simultaneous set and clear of the same bit: set wins. The pending bit stays 1, the new event is kept, and `o_merge_cnt` does not increment.
- Masked pending bits stay pending and still coalesce. They become eligible in the cycle after the mask clears.
- A mask change while in REQ does not withdraw the issued request.

## Timing
- Reset values (asynchronous, immediate): `o_msix_valid`=0, `o_msix_afu`=0, `o_msix_vector`=0, `o_irq_pending`=0, `o_merge_cnt`=0, FSM=IDLE, rr_ptr=NUM_AFUS-1.
- Latency: pulse in cycle t → pending visible in t+1 → `o_msix_valid`=1 in t+2 (if in IDLE). The winner's pending bit reads 0 from t+2.
- Throughput: at most one request per 2 cycles, because the FSM passes through IDLE after each handshake.
- `o_msix_valid` never deasserts without `i_msix_ready`, except on reset. Reset mid-REQ drops the request and all pending state.

## Configuration
- `OFS_FIM_IRQ_MASK_EN` defined: `i_vec_mask` port present; masking behaves as described above.
- Not defined: port absent; every pending bit is eligible.

## Test plan
All scenarios use NUM_AFUS=2, NUM_AFU_INTERRUPTS=7.
- Single pulse on bit 3 at cycle 10 → `o_irq_pending[3]`=1 at cycle 11; valid=1, afu=0, vector=3 at cycle 12; with ready held high, valid=0 at 13.
- Pulse bits 2 and 5 (AFU0) and bit 8 (AFU1 vec1) together → grant order (0,2), (1,1), (0,5).
- Ready held low for 20 cycles → valid, afu and vector stay constant; pulse bit 2 again while bit 2 pending → `o_merge_cnt`=1.
- Pulse bit 4 in the same cycle it is granted (cleared) → pending stays 1; a second grant of (0,4) follows; `o_merge_cnt` unchanged.
- With the macro: mask=0x0001, pulse bit 0 → no valid for 10 cycles, pending[0]=1; clear mask → valid 2 cycles later with (0,0).
- Assert rst_n=0 during REQ → valid, pending and `o_merge_cnt` go to 0 immediately; after release, AFU 0 has first priority again.

Source files
------------

// File: rtl/afu_irq_arbiter.sv
// Per-vector pending-bit collector and single-outstanding MSI-X request issuer.
// Round-robin across AFUs, lowest vector first within an AFU; optional masking via OFS_FIM_IRQ_MASK_EN.
module afu_irq_arbiter #(
  parameter int NUM_AFUS             = 1,
  parameter int NUM_AFU_INTERRUPTS   = 7,
  parameter int LNUM_AFUS            = (NUM_AFUS > 1) ? $clog2(NUM_AFUS) : 1,
  parameter int L_NUM_AFU_INTERRUPTS = $clog2(NUM_AFU_INTERRUPTS)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_AFUS*NUM_AFU_INTERRUPTS-1:0]     i_afu_irq_req,
`ifdef OFS_FIM_IRQ_MASK_EN
  input  logic [NUM_AFUS*NUM_AFU_INTERRUPTS-1:0]     i_vec_mask,
`endif
  output logic [NUM_AFUS*NUM_AFU_INTERRUPTS-1:0]     o_irq_pending,
  output logic                                       o_msix_valid,
  output logic [LNUM_AFUS-1:0]                       o_msix_afu,
  output logic [L_NUM_AFU_INTERRUPTS-1:0]            o_msix_vector,
  input  logic                                       i_msix_ready,
  output logic [15:0]                                o_merge_cnt
);

  localparam int NB    = NUM_AFUS * NUM_AFU_INTERRUPTS;
  localparam int L_VEC = L_NUM_AFU_INTERRUPTS;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                    state_reg;
  logic [NB-1:0]             pending_reg;
  logic [15:0]               merge_cnt_reg;
  logic [15:0]               merge_next;
  logic [LNUM_AFUS-1:0]      rr_ptr_reg;
  logic                      valid_reg;
  logic [LNUM_AFUS-1:0]      afu_reg;
  logic [L_VEC-1:0]          vec_reg;

  logic [NB-1:0]             eligible;
  logic [NB-1:0]             grant_clr;
  logic [NB-1:0]             coalesce;
  logic [NUM_AFUS-1:0]       afu_any;
  logic [NUM_AFUS*L_VEC-1:0] afu_vec_flat;
  logic                      win_found;
  logic [LNUM_AFUS-1:0]      win_afu;
  logic [L_VEC-1:0]          win_vec;
  logic                      grant;

`ifdef OFS_FIM_IRQ_MASK_EN
  // Mask is registered so a cleared mask makes its vector eligible one cycle later.
  logic [NB-1:0] mask_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_reg <= '0;
    else        mask_reg <= i_vec_mask;
  end

  assign eligible = pending_reg & ~mask_reg;
`else
  assign eligible = pending_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AFUS; gi++) begin : g_afu
      logic [L_VEC-1:0] low_vec;

      always_comb begin
        low_vec = '0;
        for (int v = NUM_AFU_INTERRUPTS - 1; v >= 0; v--) begin
          if (eligible[gi*NUM_AFU_INTERRUPTS + v]) low_vec = L_VEC'(v);
        end
      end

      assign afu_any[gi]                        = |eligible[gi*NUM_AFU_INTERRUPTS +: NUM_AFU_INTERRUPTS];
      assign afu_vec_flat[gi*L_VEC +: L_VEC]    = low_vec;
    end
  endgenerate

  // Scan starts one past the last granted AFU.
  always_comb begin
    int a;
    a         = 0;
    win_found = 1'b0;
    win_afu   = '0;
    win_vec   = '0;
    for (int k = 1; k <= NUM_AFUS; k++) begin
      a = (int'(rr_ptr_reg) + k) % NUM_AFUS;
      if (!win_found && afu_any[a]) begin
        win_found = 1'b1;
        win_afu   = LNUM_AFUS'(a);
        win_vec   = afu_vec_flat[a*L_VEC +: L_VEC];
      end
    end
  end

  assign grant = (state_reg == IDLE) && win_found;

  always_comb begin
    grant_clr = '0;
    if (grant) begin
      for (int i = 0; i < NB; i++) begin
        if (i == int'(win_afu) * NUM_AFU_INTERRUPTS + int'(win_vec)) grant_clr[i] = 1'b1;
      end
    end
  end

  // A pulse landing on the bit being cleared re-arms it and is not a merge.
  always_comb begin
    int merge_sum;
    coalesce  = i_afu_irq_req & pending_reg & ~grant_clr;
    merge_sum = int'(merge_cnt_reg);
    for (int i = 0; i < NB; i++) begin
      if (coalesce[i]) merge_sum = merge_sum + 1;
    end
    merge_next = (merge_sum > 65535) ? 16'hFFFF : merge_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg   <= '0;
      merge_cnt_reg <= '0;
    end else begin
      pending_reg   <= (pending_reg & ~grant_clr) | i_afu_irq_req;
      merge_cnt_reg <= merge_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      valid_reg  <= 1'b0;
      afu_reg    <= '0;
      vec_reg    <= '0;
      rr_ptr_reg <= LNUM_AFUS'(NUM_AFUS - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            afu_reg   <= win_afu;
            vec_reg   <= win_vec;
            valid_reg <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (i_msix_ready) begin
            valid_reg  <= 1'b0;
            rr_ptr_reg <= afu_reg;
            state_reg  <= IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_irq_pending = pending_reg;
  assign o_msix_valid  = valid_reg;
  assign o_msix_afu    = afu_reg;
  assign o_msix_vector = vec_reg;
  assign o_merge_cnt   = merge_cnt_reg;

endmodule

// File: tb/tb_afu_irq_arbiter.sv
// Directed bench for afu_irq_arbiter with 2 AFUs x 7 vectors; mask scenario runs when OFS_FIM_IRQ_MASK_EN is defined.
module tb_afu_irq_arbiter;
  localparam int NA = 2;
  localparam int NV = 7;
  localparam int NB = NA * NV;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] req   = '0;
  logic          ready = 1'b0;
  logic [NB-1:0] pending;
  logic          valid;
  logic [0:0]    afu;
  logic [2:0]    vec;
  logic [15:0]   merge;
`ifdef OFS_FIM_IRQ_MASK_EN
  logic [NB-1:0] mask = '0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  afu_irq_arbiter #(
    .NUM_AFUS(NA),
    .NUM_AFU_INTERRUPTS(NV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_afu_irq_req(req),
`ifdef OFS_FIM_IRQ_MASK_EN
    .i_vec_mask(mask),
`endif
    .o_irq_pending(pending),
    .o_msix_valid(valid),
    .o_msix_afu(afu),
    .o_msix_vector(vec),
    .i_msix_ready(ready),
    .o_merge_cnt(merge)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NB-1:0] bits);
    req = bits;
    tick();
    req = '0;
  endtask

  task automatic grant_chk(input string tag, input logic [0:0] a, input logic [2:0] v);
    check({tag, "_valid"}, valid, 1'b1);
    check({tag, "_afu"}, afu, a);
    check({tag, "_vec"}, vec, v);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b0;
`ifdef OFS_FIM_IRQ_MASK_EN
    mask  = '0;
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_valid", valid, 1'b0);
    check("rst_afu", afu, 1'b0);
    check("rst_vec", vec, 3'd0);
    check("rst_pending", pending, 14'h0);
    check("rst_merge", merge, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pulse on bit 3
    ready = 1'b1;
    pulse(14'h0008);
    check("t1_pend", pending, 14'h0008);
    check("t1_novalid", valid, 1'b0);
    tick();
    grant_chk("t1_grant", 1'b0, 3'd3);
    check("t1_pend_clr", pending, 14'h0);
    tick();
    check("t1_drop", valid, 1'b0);

    // Round-robin order across AFUs
    do_reset();
    ready = 1'b1;
    pulse(14'h0124);
    check("t2_pend", pending, 14'h0124);
    tick();
    grant_chk("t2_g0", 1'b0, 3'd2);
    check("t2_pend0", pending, 14'h0120);
    tick();
    check("t2_gap0", valid, 1'b0);
    tick();
    grant_chk("t2_g1", 1'b1, 3'd1);
    check("t2_pend1", pending, 14'h0020);
    tick();
    check("t2_gap1", valid, 1'b0);
    tick();
    grant_chk("t2_g2", 1'b0, 3'd5);
    check("t2_pend2", pending, 14'h0);
    tick();
    check("t2_gap2", valid, 1'b0);

    // Backpressure hold and coalescing
    do_reset();
    ready = 1'b0;
    pulse(14'h0004);
    tick();
    grant_chk("t3_grant", 1'b0, 3'd2);
    pulse(14'h0004);
    check("t3_repend", pending, 14'h0004);
    check("t3_merge0", merge, 16'd0);
    pulse(14'h0004);
    check("t3_merge1", merge, 16'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      grant_chk("t3_hold", 1'b0, 3'd2);
    end
    ready = 1'b1;
    tick();
    check("t3_drop", valid, 1'b0);
    tick();
    grant_chk("t3_regrant", 1'b0, 3'd2);
    check("t3_pend", pending, 14'h0);
    tick();
    check("t3_drop2", valid, 1'b0);
    check("t3_merge_end", merge, 16'd1);

    // Set wins over clear on the granted bit
    do_reset();
    ready = 1'b1;
    pulse(14'h0010);
    check("t4_pend", pending, 14'h0010);
    pulse(14'h0010);
    grant_chk("t4_g0", 1'b0, 3'd4);
    check("t4_keep", pending, 14'h0010);
    check("t4_merge", merge, 16'd0);
    tick();
    check("t4_drop", valid, 1'b0);
    tick();
    grant_chk("t4_g1", 1'b0, 3'd4);
    check("t4_pend_clr", pending, 14'h0);
    tick();
    check("t4_drop2", valid, 1'b0);
    check("t4_merge_end", merge, 16'd0);

`ifdef OFS_FIM_IRQ_MASK_EN
    // Masked vector stays pending until the mask clears
    do_reset();
    ready = 1'b1;
    mask  = 14'h0001;
    pulse(14'h0001);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_masked", valid, 1'b0);
    end
    check("t5_pend", pending, 14'h0001);
    pulse(14'h0001);
    check("t5_merge", merge, 16'd1);
    mask = 14'h0;
    tick();
    check("t5_wait", valid, 1'b0);
    tick();
    grant_chk("t5_grant", 1'b0, 3'd0);
    tick();
    check("t5_drop", valid, 1'b0);
`endif

    // Asynchronous reset during REQ
    do_reset();
    ready = 1'b1;
    pulse(14'h0001);
    tick();
    grant_chk("t6_g0", 1'b0, 3'd0);
    tick();
    check("t6_drop", valid, 1'b0);
    ready = 1'b0;
    pulse(14'h0108);
    tick();
    grant_chk("t6_rr", 1'b1, 3'd1);
    check("t6_pend", pending, 14'h0008);
    pulse(14'h0008);
    check("t6_merge", merge, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", valid, 1'b0);
    check("t6_rst_pend", pending, 14'h0);
    check("t6_rst_merge", merge, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    pulse(14'h0108);
    tick();
    grant_chk("t6_after", 1'b0, 3'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
